program_counter_stack: RTL and testbench
========================================

# program_counter_stack

Parametrised successor to the 4-bit SAP-style program counter. Holds a WIDTH-bit instruction address. Supports clear, parallel load, increment, signed relative branch, and call/return through a DEPTH-entry hardware return stack. Sits between the control sequencer and the shared bus; the bus-drive enable keeps the legacy one-cycle registered behaviour, so existing control words still work.

## Interface
Parameters:
- WIDTH, 4, address/counter width (≥2)
- DEPTH, 4, return-stack entries (≥1)
- RESET_VALUE, 0, counter value after reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- lp  in  1  load counter from data_in
- cp  in  1  increment counter
- ep  in  1  request counter onto bus (registered)
- br  in  1  relative branch: counter += sign-extended data_in
- call  in  1  push return address, jump to data_in
- ret  in  1  pop return address into counter
- data_in  in  WIDTH  load/branch/call operand
- pc_q  out  WIDTH  current counter, always valid
- bus_out  out  WIDTH  counter when bus_oe=1, else 0
- bus_oe  out  1  registered ep
- wrap  out  1  one-cycle pulse: last increment or branch wrapped modulo 2^WIDTH
- stack_full  out  1  DEPTH entries held
- stack_empty  out  1  zero entries held
- stack_err  out  1  sticky: call-on-full or ret-on-empty seen

## Operation
- Exactly one operation runs per cycle. Priority: rst > lp > call > ret > br > cp > hold.
- rst: pc_q=RESET_VALUE, stack emptied (sp=0), bus_oe=0, wrap=0, stack_err=0. Stack contents are don't-care.
- lp: pc_q ← data_in. The stack is untouched.
- call, not full: push pc_q+1 (mod 2^WIDTH), then pc_q ← data_in, sp+1.
- call, full: pc_q unchanged, no push, stack_err←1.
- ret, not empty: pc_q ← top entry, sp−1.
- ret, empty: pc_q unchanged, stack_err←1.
- br: pc_q ← pc_q + sext(data_in). data_in is two's complement, so the range is −2^(WIDTH−1)..2^(WIDTH−1)−1. Arithmetic is modulo 2^WIDTH.
- wrap=1 in these cases:
  - cp taken and pc_q was all-ones.
  - br taken and the unsigned sum carried out (positive offset) or borrowed (negative offset).
- cp: pc_q ← pc_q+1, wrapping from all-ones to 0.
- Lower-priority requests in the same cycle are dropped, not queued.
- stack_err clears only on rst.
- stack_full = (sp==DEPTH); stack_empty = (sp==0). Both are combinational from sp.

## Timing
- All state updates on the rising edge of clk. There are no asynchronous paths.
- pc_q reflects an operation one cycle after the request is sampled.
- bus_oe follows ep with one cycle latency (bus_oe ← ep each edge).
- bus_out is combinational from bus_oe and pc_q: it shows the value held during the cycle bus_oe is high.
- A call followed immediately by ret returns to call-address+1 in two cycles. No bubble is needed.
- rst asserted mid-sequence (for example, with call and ret high) overrides everything at that edge.

## Structure
- Package pc_pkg holds:
  - the operation enum: OP_HOLD, OP_INC, OP_BR, OP_RET, OP_CALL, OP_LOAD, OP_RST;
  - the priority-decode function mapping {rst, lp, call, ret, br, cp} to op.
- Sub-module pc_return_stack (parameters WIDTH, DEPTH):
  - ports: clk, rst, push, pop, push_data, top, full, empty;
  - a register array plus a $clog2(DEPTH+1)-bit sp;
  - it ignores push when full and pop when empty.
- The top level does the decode, the counter and adder, wrap/err generation and the bus register.

## Test plan
- Reset/count, WIDTH=4: rst, then cp for 17 cycles → pc_q steps 0..15, 0, 1; wrap pulses in the cycle pc_q shows 0.
- Priority: pc_q=5, lp=1, cp=1, data_in=9 → pc_q=9. Then br=1, cp=1, data_in=4'b1110 → pc_q=7.
- Branch wrap: pc_q=14, br with data_in=3 → pc_q=1, wrap=1. pc_q=1, br with data_in=−2 → pc_q=15, wrap=1.
- Call/return:
  - pc_q=3, call with data_in=10 → pc_q=10, stack_empty=0.
  - cp → 11.
  - ret → pc_q=4, stack_empty=1.
- Stack bounds, DEPTH=4: five consecutive calls. The 5th leaves pc_q unchanged, stack_full=1 and stack_err=1. Then five rets: the 5th leaves pc_q unchanged and stack_err stays 1 until rst.
- Bus enable: ep high for one cycle at pc_q=6 → bus_oe=1 and bus_out=6 exactly one cycle later. Otherwise bus_out=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program counter: operation encoding and the
// priority decoder that picks exactly one operation per cycle.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_INC  = 3'd1,
        OP_BR   = 3'd2,
        OP_RET  = 3'd3,
        OP_CALL = 3'd4,
        OP_LOAD = 3'd5,
        OP_RST  = 3'd6
    } op_e;

    // rst > lp > call > ret > br > cp > hold; lower requests are dropped
    function automatic op_e decode_op(
        input logic rst,
        input logic lp,
        input logic call,
        input logic ret,
        input logic br,
        input logic cp
    );
        op_e op;
        if (rst) begin
            op = OP_RST;
        end else if (lp) begin
            op = OP_LOAD;
        end else if (call) begin
            op = OP_CALL;
        end else if (ret) begin
            op = OP_RET;
        end else if (br) begin
            op = OP_BR;
        end else if (cp) begin
            op = OP_INC;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// DEPTH-entry LIFO of return addresses. Push on full and pop on empty are
// ignored here; the caller is responsible for flagging them.
module pc_return_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int SPW = $clog2(DEPTH + 1);
    // Storage is sized to the full sp range so sp can index it directly
    localparam int SLOTS = 1 << SPW;

    logic [WIDTH-1:0] entries_q [0:SLOTS-1];
    logic [SPW-1:0]   sp_q;
    logic [SPW-1:0]   sp_d;
    logic [SPW-1:0]   top_idx_s;

    assign full      = (sp_q == SPW'(DEPTH));
    assign empty     = (sp_q == {SPW{1'b0}});
    assign top_idx_s = sp_q - {{(SPW-1){1'b0}}, 1'b1};
    assign top       = entries_q[top_idx_s];

    // Next stack pointer
    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + {{(SPW-1){1'b0}}, 1'b1};
        end else if (pop && !empty) begin
            sp_d = top_idx_s;
        end else begin
            sp_d = sp_q;
        end
    end

    // Stack pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= {SPW{1'b0}};
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage; contents after reset are don't-care
    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            entries_q[sp_q] <= push_data;
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// WIDTH-bit program counter with load, increment, relative branch and
// call/return through a hardware return stack; legacy registered bus drive.
module program_counter_stack
    import pc_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lp,
    input  logic             cp,
    input  logic             ep,
    input  logic             br,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] pc_q,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    output logic             wrap,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    op_e              op_s;
    logic [WIDTH-1:0] pc_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             err_q;
    logic             err_d;
    logic             bus_oe_q;
    logic             push_s;
    logic             pop_s;
    logic [WIDTH-1:0] top_s;
    logic [WIDTH-1:0] ret_addr_s;
    logic             full_s;
    logic             empty_s;
    logic [WIDTH:0]   inc_sum_s;
    logic [WIDTH:0]   br_sum_s;

    assign op_s = decode_op(rst, lp, call, ret, br, cp);

    // Carry out of the raw add: for a negative offset, no carry means a borrow
    assign inc_sum_s  = {1'b0, pc_q} + {{WIDTH{1'b0}}, 1'b1};
    assign br_sum_s   = {1'b0, pc_q} + {1'b0, data_in};
    assign ret_addr_s = inc_sum_s[WIDTH-1:0];

    pc_return_stack #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (ret_addr_s),
        .top       (top_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Next-state for counter, wrap pulse, sticky error and stack control
    always_comb begin
        pc_d   = pc_q;
        wrap_d = 1'b0;
        err_d  = err_q;
        push_s = 1'b0;
        pop_s  = 1'b0;
        case (op_s)
            OP_RST: begin
                pc_d  = RESET_VALUE;
                err_d = 1'b0;
            end
            OP_LOAD: begin
                pc_d = data_in;
            end
            OP_CALL: begin
                if (!full_s) begin
                    push_s = 1'b1;
                    pc_d   = data_in;
                end else begin
                    err_d = 1'b1;
                end
            end
            OP_RET: begin
                if (!empty_s) begin
                    pop_s = 1'b1;
                    pc_d  = top_s;
                end else begin
                    err_d = 1'b1;
                end
            end
            OP_BR: begin
                pc_d   = br_sum_s[WIDTH-1:0];
                wrap_d = data_in[WIDTH-1] ? ~br_sum_s[WIDTH] : br_sum_s[WIDTH];
            end
            OP_INC: begin
                pc_d   = inc_sum_s[WIDTH-1:0];
                wrap_d = inc_sum_s[WIDTH];
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // Counter, status and bus-enable registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_VALUE;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
            bus_oe_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
            bus_oe_q <= ep;
        end
    end

    assign wrap        = wrap_q;
    assign stack_err   = err_q;
    assign bus_oe      = bus_oe_q;
    assign bus_out     = bus_oe_q ? pc_q : {WIDTH{1'b0}};
    assign stack_full  = full_s;
    assign stack_empty = empty_s;

endmodule

// File: tb/tb_program_counter_stack.sv
// Scoreboard bench for program_counter_stack: directed scenarios then random
// traffic, checked against an integer/queue reference model.
module tb_program_counter_stack;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int M     = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst, lp, cp, ep, br, call, ret;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] pc_q, bus_out;
    logic             bus_oe, wrap, stack_full, stack_empty, stack_err;

    program_counter_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .lp(lp), .cp(cp), .ep(ep), .br(br),
        .call(call), .ret(ret), .data_in(data_in), .pc_q(pc_q),
        .bus_out(bus_out), .bus_oe(bus_oe), .wrap(wrap),
        .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc; bit wrap; bit oe; int bus; bit full; bit empty; bit err; int id;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step_id = 0;

    // reference model state
    int   m_pc = 0;
    int   m_stk[$];
    bit   m_err = 1'b0;

    task automatic check(input string name, input int id, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %0d expected %0d", name, id, act, exp);
        end
    endtask

    // monitor: pops one expectation per clock edge and compares
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pc_q",        e.id, int'(pc_q),        e.pc);
                check("wrap",        e.id, int'(wrap),        int'(e.wrap));
                check("bus_oe",      e.id, int'(bus_oe),      int'(e.oe));
                check("bus_out",     e.id, int'(bus_out),     e.bus);
                check("stack_full",  e.id, int'(stack_full),  int'(e.full));
                check("stack_empty", e.id, int'(stack_empty), int'(e.empty));
                check("stack_err",   e.id, int'(stack_err),   int'(e.err));
            end
        end
    end

    task automatic step(input bit r, input bit l, input bit c, input bit e,
                        input bit b, input bit ca, input bit rt, input int d);
        exp_t x;
        int   s;
        int   off;
        bit   w;
        @(negedge clk);
        rst = r; lp = l; cp = c; ep = e; br = b; call = ca; ret = rt;
        data_in = WIDTH'(d);
        w = 1'b0;
        if (r) begin
            m_pc = 0; m_stk.delete(); m_err = 1'b0;
        end else if (l) begin
            m_pc = d;
        end else if (ca) begin
            if (m_stk.size() == DEPTH) m_err = 1'b1;
            else begin
                m_stk.push_back((m_pc + 1) % M);
                m_pc = d;
            end
        end else if (rt) begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else m_pc = m_stk.pop_back();
        end else if (b) begin
            off  = (d >= M / 2) ? d - M : d;
            s    = m_pc + off;
            w    = (s < 0) || (s >= M);
            m_pc = (s + M) % M;
        end else if (c) begin
            s    = m_pc + 1;
            w    = (s == M);
            m_pc = s % M;
        end
        x.pc    = m_pc;
        x.wrap  = w;
        x.oe    = e && !r;
        x.bus   = (e && !r) ? m_pc : 0;
        x.full  = (m_stk.size() == DEPTH);
        x.empty = (m_stk.size() == 0);
        x.err   = m_err;
        x.id    = step_id;
        step_id++;
        exp_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    // op shorthands: rst lp cp ep br call ret data
    task automatic do_rst();            step(1,0,0,0,0,0,0,0); endtask
    task automatic do_load(input int d); step(0,1,0,0,0,0,0,d); endtask
    task automatic do_inc();            step(0,0,1,0,0,0,0,0); endtask
    task automatic do_br(input int d);   step(0,0,0,0,1,0,0,d); endtask
    task automatic do_call(input int d); step(0,0,0,0,0,1,0,d); endtask
    task automatic do_ret();            step(0,0,0,0,0,0,1,0); endtask

    initial begin
        int wait_cyc;
        rst = 1'b0; lp = 1'b0; cp = 1'b0; ep = 1'b0; br = 1'b0;
        call = 1'b0; ret = 1'b0; data_in = '0;

        do_rst();
        check("reset pc", 0, int'(pc_q), 0);
        for (int i = 0; i < 17; i++) begin
            do_inc();
            if (i == 15) check("count wrap pulse", i, int'(wrap), 1);
        end
        check("count end", 0, int'(pc_q), 1);

        do_load(5);
        step(0,1,1,0,0,0,0,9);
        check("lp over cp", 0, int'(pc_q), 9);
        step(0,0,1,0,1,0,0,14);
        check("br over cp", 0, int'(pc_q), 7);

        do_load(14);
        do_br(3);
        check("br fwd wrap", 0, int'(pc_q) * 2 + int'(wrap), 3);
        do_br(14);
        check("br back wrap", 0, int'(pc_q) * 2 + int'(wrap), 31);
        do_br(0);
        do_load(2);
        do_br(14);

        do_load(3);
        do_call(10);
        check("call target", 0, int'(pc_q), 10);
        do_inc();
        do_ret();
        check("ret addr", 0, int'(pc_q), 4);
        do_call(12);
        do_ret();
        check("call-ret back to back", 0, int'(pc_q), 5);

        do_load(0);
        for (int i = 1; i <= 5; i++) do_call(i);
        check("overflow pc", 0, int'(pc_q), 4);
        check("overflow err", 0, int'(stack_err), 1);
        for (int i = 0; i < 5; i++) do_ret();
        check("underflow pc", 0, int'(pc_q), 1);
        do_inc();
        check("err sticky", 0, int'(stack_err), 1);
        step(1,0,0,0,0,1,1,7);
        check("rst clears err", 0, int'(stack_err), 0);

        do_load(6);
        step(0,0,0,1,0,0,0,0);
        check("bus drive", 0, int'(bus_out), 6);
        step(0,0,0,0,0,0,0,0);
        check("bus idle", 0, int'(bus_out), 0);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, M - 1));
        end

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
